// File: rtl/barrel_pool.sv
// barrel_pool: spawns barrels on the top floor, rolls them, drops them floor to floor, despawns them at the bottom.
// Define BARREL_POOL_LFSR_DIR_EN to pick each spawn direction from an 8-bit LFSR instead of always rolling right.
module barrel_pool #(
   parameter int NUM_BARRELS  = 4,
   parameter int NUM_FLOORS   = 4,
   parameter int TOP_Y        = 100,
   parameter int FLOOR_PITCH  = 80,
   parameter int LEFT_X       = 50,
   parameter int RIGHT_X      = 590,
   parameter int SPAWN_X      = 250,
   parameter int SPEED_X      = 3,
   parameter int MAX_FALL     = 7,
   parameter int SPAWN_PERIOD = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tick,
   input  logic                      start,
   input  logic                      over,
   output logic [10*NUM_BARRELS-1:0] x_bus,
   output logic [9*NUM_BARRELS-1:0]  y_bus,
   output logic [2*NUM_BARRELS-1:0]  state_bus,
   output logic [3*NUM_BARRELS-1:0]  anim_bus,
   output logic [NUM_BARRELS-1:0]    active,
   output logic                      spawn_pulse
);
   localparam int CW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SPAWN_PERIOD - 1);
   localparam logic [1:0] S_IDLE = 2'b00, S_ROLL = 2'b01, S_FALL = 2'b10;
   typedef enum logic {P_IDLE, P_RUN} pool_t;
   pool_t                  pool_q, pool_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   spawn_pulse_q, spawn_pulse_d;
   logic [9:0]             x_q [NUM_BARRELS], x_d [NUM_BARRELS];
   logic [8:0]             y_q [NUM_BARRELS], y_d [NUM_BARRELS];
   logic [2:0]             vy_q [NUM_BARRELS], vy_d [NUM_BARRELS];
   logic [2:0]             fl_q [NUM_BARRELS], fl_d [NUM_BARRELS];
   logic [1:0]             st_q [NUM_BARRELS], st_d [NUM_BARRELS];
   logic [4:0]             ac_q [NUM_BARRELS], ac_d [NUM_BARRELS];
   logic [2:0]             anim_q [NUM_BARRELS], anim_d [NUM_BARRELS];
   logic [NUM_BARRELS-1:0] dir_q, dir_d, act_q, act_d;
   logic [10:0]            x_r [NUM_BARRELS];
   logic [9:0]             x_m [NUM_BARRELS], y_n [NUM_BARRELS], ty [NUM_BARRELS];
   logic [2:0]             vy_n [NUM_BARRELS];
   logic                   has_free, do_spawn, spawn_dir;
   logic [2:0]             free_idx;
`ifdef BARREL_POOL_LFSR_DIR_EN
   logic [7:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = tick ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
   always_comb spawn_dir = lfsr_d[0];
   always_ff @(posedge clk or negedge rst)
      if (!rst) lfsr_q <= 8'hA5;
      else lfsr_q <= lfsr_d;
`else
   always_comb spawn_dir = 1'b0;
`endif
   always_comb begin
      pool_d = pool_q;
      cnt_d = cnt_q;
      has_free = 1'b0;
      free_idx = '0;
      dir_d = dir_q;
      act_d = '0;
      // free slots are judged on pre-update state, so a slot despawning this tick is not reused yet
      for (int i = NUM_BARRELS - 1; i >= 0; i--)
         if (st_q[i] == S_IDLE) begin
            has_free = 1'b1;
            free_idx = 3'(i);
         end
      do_spawn = pool_q == P_RUN && tick && !over && cnt_q == CNT_MAX && has_free;
      spawn_pulse_d = do_spawn;
      if (over) begin
         pool_d = P_IDLE;
         cnt_d = '0;
      end else if (pool_q == P_IDLE) begin
         if (start) begin
            pool_d = P_RUN;
            cnt_d = CNT_MAX;
         end
      end else if (tick)
         cnt_d = (cnt_q != CNT_MAX) ? cnt_q + 1'b1 : (has_free ? '0 : CNT_MAX);
      for (int i = 0; i < NUM_BARRELS; i++) begin
         x_d[i] = x_q[i];
         y_d[i] = y_q[i];
         vy_d[i] = vy_q[i];
         fl_d[i] = fl_q[i];
         st_d[i] = st_q[i];
         ac_d[i] = ac_q[i];
         x_r[i] = {1'b0, x_q[i]} + 11'(SPEED_X);
         x_m[i] = dir_q[i] ? ((x_q[i] < 10'(LEFT_X + SPEED_X)) ? 10'(LEFT_X) : x_q[i] - 10'(SPEED_X))
                           : ((x_r[i] > 11'(RIGHT_X)) ? 10'(RIGHT_X) : x_r[i][9:0]);
         vy_n[i] = (vy_q[i] >= 3'(MAX_FALL)) ? 3'(MAX_FALL) : vy_q[i] + 3'd1;
         y_n[i] = {1'b0, y_q[i]} + {7'd0, vy_n[i]};
         ty[i] = 10'(TOP_Y + (int'(fl_q[i]) + 1) * FLOOR_PITCH);
         if (over || (do_spawn && free_idx == 3'(i))) begin
            x_d[i] = over ? 10'd0 : 10'(SPAWN_X);
            y_d[i] = over ? 9'd0 : 9'(TOP_Y);
            vy_d[i] = '0;
            fl_d[i] = '0;
            ac_d[i] = '0;
            st_d[i] = over ? S_IDLE : S_ROLL;
            dir_d[i] = over ? 1'b0 : spawn_dir;
         end else if (tick && st_q[i] != S_IDLE) begin
            ac_d[i] = ac_q[i] + 5'd1;
            if (st_q[i] == S_ROLL) begin
               x_d[i] = x_m[i];
               if (x_m[i] == (dir_q[i] ? 10'(LEFT_X) : 10'(RIGHT_X))) begin
                  if (fl_q[i] < 3'(NUM_FLOORS - 1)) begin
                     st_d[i] = S_FALL;
                     vy_d[i] = '0;
                     dir_d[i] = ~dir_q[i];
                  end else begin
                     x_d[i] = '0;
                     y_d[i] = '0;
                     fl_d[i] = '0;
                     ac_d[i] = '0;
                     dir_d[i] = 1'b0;
                     st_d[i] = S_IDLE;
                  end
               end
            end else if (y_n[i] >= ty[i]) begin
               y_d[i] = ty[i][8:0];
               fl_d[i] = fl_q[i] + 3'd1;
               st_d[i] = S_ROLL;
               vy_d[i] = '0;
            end else begin
               y_d[i] = y_n[i][8:0];
               vy_d[i] = vy_n[i];
            end
         end
         act_d[i] = st_d[i] != S_IDLE;
         anim_d[i] = (st_d[i] == S_ROLL) ? {1'b0, ac_d[i][4:3]} :
                     (st_d[i] == S_FALL) ? (ac_d[i][4] ? 3'd4 : 3'd5) : 3'd0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pool_q <= P_IDLE;
         cnt_q <= '0;
         spawn_pulse_q <= 1'b0;
         x_q <= '{default: '0};
         y_q <= '{default: '0};
         vy_q <= '{default: '0};
         fl_q <= '{default: '0};
         st_q <= '{default: '0};
         ac_q <= '{default: '0};
         anim_q <= '{default: '0};
         dir_q <= '0;
         act_q <= '0;
      end else begin
         pool_q <= pool_d;
         cnt_q <= cnt_d;
         spawn_pulse_q <= spawn_pulse_d;
         x_q <= x_d;
         y_q <= y_d;
         vy_q <= vy_d;
         fl_q <= fl_d;
         st_q <= st_d;
         ac_q <= ac_d;
         anim_q <= anim_d;
         dir_q <= dir_d;
         act_q <= act_d;
      end
   end
   always_comb begin
      x_bus = '0;
      y_bus = '0;
      state_bus = '0;
      anim_bus = '0;
      for (int i = 0; i < NUM_BARRELS; i++) begin
         x_bus[10*i +: 10] = x_q[i];
         y_bus[9*i +: 9] = y_q[i];
         state_bus[2*i +: 2] = st_q[i];
         anim_bus[3*i +: 3] = anim_q[i];
      end
   end
   assign active = act_q;
   assign spawn_pulse = spawn_pulse_q;
endmodule
